// File: rtl/mor1kx_pic_irq_sched_pkg.sv
// Shared constants for the PIC interrupt scheduler: state encoding and IRQ id width.
package mor1kx_pic_irq_sched_pkg;

  localparam int unsigned IRQ_ID_W = 5;
  localparam int unsigned IRQ_NUM  = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } pic_state_e;

endpackage

// File: rtl/mor1kx_pic_prio_enc.sv
// 32-bit find-first-set starting at a rotating base; o_idx is the absolute line number.
module mor1kx_pic_prio_enc
  import mor1kx_pic_irq_sched_pkg::*;
(
  input  logic [IRQ_NUM-1:0]  i_vec,
  input  logic [IRQ_ID_W-1:0] i_base,
  output logic [IRQ_ID_W-1:0] o_idx,
  output logic                o_valid
);

  logic [IRQ_NUM-1:0]  w_rot;
  logic [IRQ_ID_W-1:0] w_pos;

  // Rotate so the base line lands at bit 0, then take the lowest set bit.
  always_comb begin
    w_rot = 32'({i_vec, i_vec} >> i_base);
    w_pos = '0;
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (w_rot[i]) w_pos = IRQ_ID_W'(i);
    end
  end

  assign o_idx   = w_pos + i_base;
  assign o_valid = |i_vec;

endmodule

// File: rtl/mor1kx_pic_irq_sched.sv
// PIC interrupt scheduler: picks one pending line, presents it with a req/ack
// handshake, tracks in-service lines and retires them on EOI.
module mor1kx_pic_irq_sched
  import mor1kx_pic_irq_sched_pkg::*;
#(
  parameter string       OPTION_PIC_PRIORITY  = "FIXED",
  parameter int unsigned OPTION_PIC_NESTING   = 1,
  parameter int unsigned OPTION_PIC_NMI_WIDTH = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IRQ_NUM-1:0]  picsr_i,
  input  logic [IRQ_NUM-1:0]  picmr_i,
  input  logic                irq_enable_i,
  input  logic                irq_ack_i,
  input  logic                eoi_i,
  output logic                irq_req_o,
  output logic [IRQ_ID_W-1:0] irq_id_o,
  output logic [IRQ_NUM-1:0]  isr_o,
  output logic                busy_o
);

  localparam bit                 RR       = (OPTION_PIC_PRIORITY == "ROUND_ROBIN");
  localparam bit                 NEST     = !RR && (OPTION_PIC_NESTING != 0);
  localparam logic [IRQ_NUM-1:0] NMI_MASK = 32'((64'd1 << OPTION_PIC_NMI_WIDTH) - 64'd1);

  pic_state_e          r_state;
  logic                r_irq_req;
  logic [IRQ_ID_W-1:0] r_irq_id;
  logic [IRQ_NUM-1:0]  r_isr;
  logic                r_busy;
  logic [IRQ_ID_W-1:0] r_rr_base;

  logic [IRQ_NUM-1:0]  w_pending;
  logic [IRQ_NUM-1:0]  w_below;
  logic [IRQ_NUM-1:0]  w_cand;
  logic [IRQ_NUM-1:0]  w_isr_nxt;
  logic [IRQ_ID_W-1:0] w_sel;
  logic [IRQ_ID_W-1:0] w_sel_base;
  logic [IRQ_ID_W-1:0] w_isr_low;
  logic                w_cand_valid;
  logic                w_isr_valid;
  logic                w_eligible;

  assign w_pending  = picsr_i & picmr_i;
  assign w_below    = 32'((64'd1 << w_isr_low) - 64'd1);
  assign w_sel_base = RR ? r_rr_base : '0;

  // Only strictly higher-priority lines may pre-empt an in-service line.
  always_comb begin
    w_cand = '0;
    if (!w_isr_valid)
      w_cand = w_pending;
    else if (NEST)
      w_cand = w_pending & ~r_isr & w_below;
  end

  mor1kx_pic_prio_enc u_sel_enc (
    .i_vec   (w_cand),
    .i_base  (w_sel_base),
    .o_idx   (w_sel),
    .o_valid (w_cand_valid)
  );

  mor1kx_pic_prio_enc u_isr_enc (
    .i_vec   (r_isr),
    .i_base  (IRQ_ID_W'(0)),
    .o_idx   (w_isr_low),
    .o_valid (w_isr_valid)
  );

  assign w_eligible = w_cand_valid && (irq_enable_i || NMI_MASK[w_sel]);

  // EOI retires the lowest in-service line before an ack marks the new one.
  always_comb begin
    w_isr_nxt = r_isr;
    if (eoi_i && w_isr_valid)
      w_isr_nxt[w_isr_low] = 1'b0;
    if ((r_state == ST_REQ) && irq_ack_i)
      w_isr_nxt[r_irq_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_irq_req <= 1'b0;
      r_irq_id  <= '0;
      r_isr     <= '0;
      r_busy    <= 1'b0;
      r_rr_base <= '0;
    end else begin
      r_isr  <= w_isr_nxt;
      r_busy <= |w_isr_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_eligible) begin
            r_state   <= ST_REQ;
            r_irq_req <= 1'b1;
            r_irq_id  <= w_sel;
          end
        end
        ST_REQ: begin
          if (irq_ack_i) begin
            r_state   <= ST_HOLD;
            r_irq_req <= 1'b0;
            r_rr_base <= r_irq_id + IRQ_ID_W'(1);
          end else if (!w_pending[r_irq_id]) begin
            r_state   <= ST_IDLE;
            r_irq_req <= 1'b0;
          end
        end
        ST_HOLD: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_irq_req <= 1'b0;
        end
      endcase
    end
  end

  assign irq_req_o = r_irq_req;
  assign irq_id_o  = r_irq_id;
  assign isr_o     = r_isr;
  assign busy_o    = r_busy;

endmodule

// File: tb/tb_mor1kx_pic_irq_sched.sv
// Directed bench for the PIC scheduler: FIXED/nesting, ROUND_ROBIN and NMI
// instances share one stimulus; each phase checks the instance it targets.
module tb_mor1kx_pic_irq_sched;

  logic        clk;
  logic        rst_n;
  logic [31:0] picsr;
  logic [31:0] picmr;
  logic        en;
  logic        ack;
  logic        eoi;

  logic        f_req, r_req, n_req;
  logic [4:0]  f_id, r_id, n_id;
  logic [31:0] f_isr, r_isr, n_isr;
  logic        f_busy, r_busy, n_busy;

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mor1kx_pic_irq_sched #(.OPTION_PIC_PRIORITY("FIXED"), .OPTION_PIC_NESTING(1),
                         .OPTION_PIC_NMI_WIDTH(0)) u_fix (
    .clk(clk), .rst_n(rst_n), .picsr_i(picsr), .picmr_i(picmr),
    .irq_enable_i(en), .irq_ack_i(ack), .eoi_i(eoi),
    .irq_req_o(f_req), .irq_id_o(f_id), .isr_o(f_isr), .busy_o(f_busy));

  mor1kx_pic_irq_sched #(.OPTION_PIC_PRIORITY("ROUND_ROBIN"), .OPTION_PIC_NESTING(1),
                         .OPTION_PIC_NMI_WIDTH(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .picsr_i(picsr), .picmr_i(picmr),
    .irq_enable_i(en), .irq_ack_i(ack), .eoi_i(eoi),
    .irq_req_o(r_req), .irq_id_o(r_id), .isr_o(r_isr), .busy_o(r_busy));

  mor1kx_pic_irq_sched #(.OPTION_PIC_PRIORITY("FIXED"), .OPTION_PIC_NESTING(1),
                         .OPTION_PIC_NMI_WIDTH(2)) u_nmi (
    .clk(clk), .rst_n(rst_n), .picsr_i(picsr), .picmr_i(picmr),
    .irq_enable_i(en), .irq_ack_i(ack), .eoi_i(eoi),
    .irq_req_o(n_req), .irq_id_o(n_id), .isr_o(n_isr), .busy_o(n_busy));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    picsr = '0;
    ack   = 1'b0;
    eoi   = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  int exp_rr[5] = '{0, 1, 3, 0, 1};

  initial begin
    rst_n = 1'b0; picsr = '0; picmr = '0; en = 1'b0; ack = 1'b0; eoi = 1'b0;
    tick(); tick();
    check("rst_req",  32'(f_req),  32'd0);
    check("rst_id",   32'(f_id),   32'd0);
    check("rst_isr",  f_isr,       32'd0);
    check("rst_busy", 32'(f_busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic request, ack, and masking by the in-service line.
    picmr = 32'hFFFF_FFFF; picsr = 32'h30; en = 1'b1;
    tick();
    check("t1_req", 32'(f_req), 32'd1);
    check("t1_id",  32'(f_id),  32'd4);
    ack = 1'b1; tick(); ack = 1'b0;
    check("t1_isr",    f_isr,       32'h10);
    check("t1_busy",   32'(f_busy), 32'd1);
    check("t1_reqlow", 32'(f_req),  32'd0);
    tick(); tick();
    check("t1_blocked", 32'(f_req), 32'd0);

    // Nested pre-emption by line 2, then two EOIs.
    picsr = 32'h14;
    tick();
    check("t2_req", 32'(f_req), 32'd1);
    check("t2_id",  32'(f_id),  32'd2);
    ack = 1'b1; tick(); ack = 1'b0;
    check("t2_isr", f_isr, 32'h14);
    picsr = 32'h0;
    eoi = 1'b1; tick(); eoi = 1'b0;
    check("t2_eoi1", f_isr, 32'h10);
    eoi = 1'b1; tick(); eoi = 1'b0;
    check("t2_eoi2",  f_isr,       32'h0);
    check("t2_busy0", 32'(f_busy), 32'd0);

    // Round-robin rotation over lines 0, 1, 3.
    do_reset();
    picsr = 32'h0B;
    for (int k = 0; k < 5; k++) begin
      int waited = 0;
      while (!r_req && waited < 10) begin
        tick();
        waited++;
      end
      check($sformatf("rr_req%0d", k), 32'(r_req), 32'd1);
      check($sformatf("rr_id%0d", k),  32'(r_id),  32'(exp_rr[k]));
      ack = 1'b1; tick(); ack = 1'b0;
      eoi = 1'b1; tick(); eoi = 1'b0;
    end

    // Withdraw when the requested line drops before ack.
    do_reset();
    picsr = 32'h80;
    tick();
    check("wd_req", 32'(f_req), 32'd1);
    check("wd_id",  32'(f_id),  32'd7);
    picsr = 32'h0;
    tick();
    check("wd_drop", 32'(f_req), 32'd0);
    check("wd_isr",  f_isr,      32'h0);
    tick();
    check("wd_idle", 32'(f_req), 32'd0);

    // NMI lines bypass the interrupt-enable.
    do_reset();
    en = 1'b0; picsr = 32'h9;
    tick();
    check("nmi_req", 32'(n_req), 32'd1);
    check("nmi_id",  32'(n_id),  32'd0);
    ack = 1'b1; tick(); ack = 1'b0;
    check("nmi_isr", n_isr, 32'h1);
    picsr = 32'h8;
    eoi = 1'b1; tick(); eoi = 1'b0;
    tick(); tick(); tick();
    check("nmi_masked", 32'(n_req), 32'd0);
    en = 1'b1;
    tick();
    check("nmi_en_req", 32'(n_req), 32'd1);
    check("nmi_en_id",  32'(n_id),  32'd3);

    // Same-cycle ack and EOI, then asynchronous reset mid-request.
    do_reset();
    picsr = 32'h20;
    tick();
    check("ae_id5", 32'(f_id), 32'd5);
    ack = 1'b1; tick(); ack = 1'b0;
    picsr = 32'h08;
    tick(); tick();
    check("ae_req", 32'(f_req), 32'd1);
    check("ae_id3", 32'(f_id),  32'd3);
    ack = 1'b1; eoi = 1'b1; tick(); ack = 1'b0; eoi = 1'b0;
    check("ae_isr", f_isr, 32'h08);
    picsr = 32'h01;
    tick(); tick();
    check("ar_req", 32'(f_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("ar_req0",  32'(f_req),  32'd0);
    check("ar_id0",   32'(f_id),   32'd0);
    check("ar_isr0",  f_isr,       32'd0);
    check("ar_busy0", 32'(f_busy), 32'd0);
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mor1kx_pic_irq_sched.md
Name: mor1kx_pic_irq_sched

Overview:
Interrupt scheduler between the PIC status/mask registers and the CPU exception logic. It picks one pending, unmasked, not-in-service line and presents it as a single vectored request with a req/ack handshake. It tracks in-service lines in a bitmask, supports nested pre-emption by higher-priority lines, and retires lines on an end-of-interrupt (EOI) pulse.

Parameters:
OPTION_PIC_PRIORITY, "FIXED", "FIXED" (line 0 highest) or "ROUND_ROBIN" (rotating base).
OPTION_PIC_NESTING, 1, 1 allows pre-emption by a strictly higher-priority line; FIXED mode only, ignored in ROUND_ROBIN.
OPTION_PIC_NMI_WIDTH, 0, lines [NMI_WIDTH-1:0] ignore irq_enable_i.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
picsr_i  in  32  PIC status register
picmr_i  in  32  PIC mask register
irq_enable_i  in  1  CPU SR interrupt-enable
irq_ack_i  in  1  CPU accepted the presented request
eoi_i  in  1  single-cycle end-of-interrupt pulse
irq_req_o  out  1  request to the CPU
irq_id_o  out  5  line number being requested
isr_o  out  32  in-service bitmask
busy_o  out  1  isr_o != 0

Behaviour:
- Reset (asynchronous on rst_n low, any state): state=IDLE, irq_req_o=0, irq_id_o=0, isr_o=0, busy_o=0, rr_base=0. Reset mid-handshake drops the request with no ack recorded.
- pending = picsr_i & picmr_i (combinational).
- cand = pending & ~isr_o. In FIXED mode with nesting=1, cand is further limited to indices strictly below the lowest set bit of isr_o. With nesting=0, or in ROUND_ROBIN mode, cand = 0 while isr_o != 0.
- Selection: FIXED picks the lowest set index of cand. ROUND_ROBIN picks the first set index at or after rr_base, wrapping 31 to 0.
- Eligible when cand != 0 and (irq_enable_i = 1 or the selected line < NMI_WIDTH).
- States:
  - IDLE: if eligible, go to REQ. irq_req_o=1 and irq_id_o=selected are registered, so the request appears 1 cycle after pending is seen.
  - REQ: irq_id_o is frozen. A higher-priority arrival does not retarget. Deasserting irq_enable_i does not withdraw.
    - On irq_ack_i: isr_o[irq_id_o]<=1, irq_req_o<=0, rr_base<=irq_id_o+1 (mod 32), go to HOLD.
    - Else, if pending[irq_id_o]=0: withdraw. irq_req_o<=0, go to IDLE.
    - ack and line drop in the same cycle: ack wins.
  - HOLD: one cycle with no request, so the CPU can clear the edge-mode picsr bit. Then go to IDLE.
- irq_ack_i outside REQ is ignored.
- EOI: eoi_i clears the lowest set bit of isr_o. It is honoured in any state. eoi_i with isr_o=0 is ignored.
- eoi_i and irq_ack_i in the same cycle: apply the EOI clear first, then set the acked bit.
- Minimum spacing between consecutive requests is 3 cycles (REQ, HOLD, IDLE).
- busy_o is registered, consistent with isr_o.

Decomposition:
- Constants in mor1kx-defines: state encodings (IDLE/REQ/HOLD, 2 bits) and IRQ ID width (5).
- One sub-module, mor1kx_pic_prio_enc: 32-bit find-first-set with a 5-bit rotate base plus a valid output. It is instantiated twice:
  - candidate selection (base = rr_base, or 0 in FIXED);
  - lowest in-service bit for EOI and the nesting limit (base = 0).

Test Plan:
- Reset, then picmr=0xFFFFFFFF, picsr=0x00000030, enable=1 -> irq_req_o=1, irq_id_o=4 on the next cycle. Ack -> isr_o=0x10. Request stays low while line 4 is in service.
- FIXED, nesting=1: isr_o=0x10, picsr=0x14 -> request id=2. Ack -> isr_o=0x14. EOI -> isr_o=0x10. EOI -> isr_o=0, busy_o=0.
- ROUND_ROBIN: picsr=0x0000000B held, ack + EOI each time -> id sequence 0,1,3,0,1.
- Withdraw: request id=7 with no ack, picsr[7] drops -> irq_req_o=0 next cycle, state IDLE, isr_o unchanged.
- NMI_WIDTH=2, enable=0, picsr=0x9 -> request id=0 only; line 3 is not requested until enable=1.
- Same-cycle ack + EOI with isr_o=0x20, ack id=3 -> isr_o=0x08. rst_n low during REQ -> all outputs 0 immediately.
